// File: rtl/random_box_painter_if.sv
// Pixel-stream bundle for random_box_painter: run control in, one plotted pixel per transfer out.
// The painter takes the master side; the pixel sink and the run controller take the slave side.
interface random_box_painter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           start;
  logic           pixel_ready;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    input  start, pixel_ready,
    output x, y, colour, plot, busy, done
  );

  modport slave (
    output start, pixel_ready,
    input  x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/random_box_painter.sv
// Paints NUM_BOXES boxes at LFSR-chosen positions, one pixel per accepted transfer.
// Define RANDOM_COLOUR_EN to take each box colour from the LFSR instead of COLOUR.
module random_box_painter #(
  parameter int          SCREEN_W  = 160,
  parameter int          SCREEN_H  = 120,
  parameter int          X_W       = 8,
  parameter int          Y_W       = 7,
  parameter int          BOX_W     = 4,
  parameter int          BOX_H     = 4,
  parameter int          NUM_BOXES = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [2:0]  COLOUR    = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  random_box_painter_if.master bus
);
  // An all-zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [X_W:0] MAX_X    = (X_W+1)'(SCREEN_W - BOX_W);
  localparam logic [Y_W:0] MAX_Y    = (Y_W+1)'(SCREEN_H - BOX_H);
  localparam logic [3:0]   COL_LAST = 4'(BOX_W - 1);
  localparam logic [3:0]   ROW_LAST = 4'(BOX_H - 1);
  localparam logic [7:0]   BOX_LAST = 8'(NUM_BOXES);

  typedef enum logic [2:0] {IDLE, GEN, DRAW, NEXT, DONE} state_t;

  state_t         state;
  logic [15:0]    lfsr;
  logic [7:0]     box_count;
  logic [7:0]     count_next;
  logic [3:0]     col;
  logic [3:0]     row;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           accept;

  // x^16+x^14+x^13+x^11+1, right-shifting form; feedback enters at bit 15.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

`ifdef RANDOM_COLOUR_EN
  function automatic logic [2:0] colour_fix(input logic [2:0] c);
    return (c == 3'b000) ? 3'b111 : c;
  endfunction
`endif

  assign cx         = lfsr[X_W-1:0];
  assign cy         = lfsr[X_W+Y_W-1:X_W];
  assign accept     = ({1'b0, cx} <= MAX_X) && ({1'b0, cy} <= MAX_Y);
  assign count_next = box_count + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED_EFF;
      box_count  <= 8'd0;
      col        <= 4'd0;
      row        <= 4'd0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= 3'b000;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            box_count <= 8'd0;
            bus.busy  <= 1'b1;
            bus.done  <= 1'b0;
            state     <= GEN;
          end
        end
        GEN: begin
          lfsr <= lfsr_next(lfsr);
          if (accept) begin
            col      <= 4'd0;
            row      <= 4'd0;
            bus.x    <= cx;
            bus.y    <= cy;
            bus.plot <= 1'b1;
`ifdef RANDOM_COLOUR_EN
            bus.colour <= colour_fix(lfsr[15:13]);
`else
            bus.colour <= COLOUR;
`endif
            state    <= DRAW;
          end
        end
        DRAW: begin
          // Outputs only move on a completed transfer, so a stalled sink sees a stable pixel.
          if (bus.pixel_ready) begin
            if (col == COL_LAST) begin
              col <= 4'd0;
              if (row == ROW_LAST) begin
                row      <= 4'd0;
                bus.plot <= 1'b0;
                state    <= NEXT;
              end else begin
                row   <= row + 4'd1;
                bus.x <= x0;
                bus.y <= y0 + Y_W'(row + 4'd1);
              end
            end else begin
              col   <= col + 4'd1;
              bus.x <= x0 + X_W'(col + 4'd1);
            end
          end
        end
        NEXT: begin
          box_count <= count_next;
          if (count_next == BOX_LAST) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            state <= GEN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Box origin is pure data, captured alongside acceptance.
  always_ff @(posedge clk) begin
    if (state == GEN && accept) begin
      x0 <= cx;
      y0 <= cy;
    end
  end
endmodule

// File: tb/tb_random_box_painter.sv
// Directed bench for random_box_painter: a default 160x120 painter and an 8x8 one-box painter.
module tb_random_box_painter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_def;
  logic [15:0] m_sml;

  int          ex0 [0:15];
  int          ey0 [0:15];
  logic [2:0]  ec  [0:15];
  int          run0_x [0:299];
  int          run0_y [0:299];
  logic [2:0]  run0_c [0:299];
  int          cap_x [0:299];
  int          cap_y [0:299];
  logic [2:0]  cap_c [0:299];
  int          cap_n;
  bit          cap_done;
  bit          cap_to;

  always #5 clk = ~clk;

  random_box_painter_if #(.X_W(8), .Y_W(7)) bd ();
  random_box_painter_if #(.X_W(3), .Y_W(3)) bs ();

  random_box_painter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bd.master)
  );

  random_box_painter #(
    .SCREEN_W(8), .SCREEN_H(8), .X_W(3), .Y_W(3), .BOX_W(4), .BOX_H(4),
    .NUM_BOXES(1), .SEED(16'h5670), .COLOUR(3'b111)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bs.master)
  );

  // Reference: try candidates until one fits, returning origin, colour and candidates tried.
  task automatic model_box(inout logic [15:0] l, input int xw, input int yw,
                           input int maxx, input int maxy,
                           output int x0, output int y0, output logic [2:0] c, output int cand);
    int  cx, cy;
    logic fb;
    x0 = 0; y0 = 0; c = 3'b000; cand = 0;
    for (int k = 0; k < 20000; k++) begin
      cx = int'(l) & ((1 << xw) - 1);
      cy = (int'(l) >> xw) & ((1 << yw) - 1);
`ifdef RANDOM_COLOUR_EN
      c = (l[15:13] == 3'b000) ? 3'b111 : l[15:13];
`else
      c = 3'b111;
`endif
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      l = (l >> 1) | ({15'd0, fb} << 15);
      cand++;
      if (cx <= maxx && cy <= maxy) begin
        x0 = cx; y0 = cy;
        break;
      end
    end
  endtask

  task automatic gen_default_boxes();
    int cand;
    for (int b = 0; b < 16; b++) model_box(m_def, 8, 7, 156, 116, ex0[b], ey0[b], ec[b], cand);
  endtask

  // Drives the default painter with pixel_ready=1 and records every transfer.
  task automatic capture_default(input bit do_start, input bit hold, input int stop_n, input int max_cyc);
    cap_n = 0; cap_done = 0; cap_to = 0;
    bd.pixel_ready = 1'b1;
    if (do_start) begin
      @(negedge clk); bd.start = 1'b1;
      @(negedge clk); if (!hold) bd.start = 1'b0;
    end
    for (int c = 0; c < max_cyc; c++) begin
      if (bd.done) begin cap_done = 1; break; end
      if (cap_n >= stop_n) break;
      if (bd.plot && bd.pixel_ready && cap_n < 300) begin
        cap_x[cap_n] = int'(bd.x);
        cap_y[cap_n] = int'(bd.y);
        cap_c[cap_n] = bd.colour;
        cap_n++;
      end
      @(negedge clk);
    end
    if (!cap_done && cap_n < stop_n) cap_to = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bd.start = 1'b0; bd.pixel_ready = 1'b0;
    bs.start = 1'b0; bs.pixel_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bd.plot !== 1'b0 || bd.busy !== 1'b0 || bd.done !== 1'b0 || bd.x !== 8'd0 || bd.y !== 7'd0 || bd.colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, want all 0",
               bd.plot, bd.busy, bd.done, bd.x, bd.y, bd.colour);
    end
    checks++;
    if (bs.plot !== 1'b0 || bs.busy !== 1'b0 || bs.done !== 1'b0 || bs.x !== 3'd0 || bs.y !== 3'd0) begin
      errors++;
      $display("FAIL reset_small: got plot=%b busy=%b done=%b x=%0d y=%0d, want all 0",
               bs.plot, bs.busy, bs.done, bs.x, bs.y);
    end
    reset = 1'b0;
    m_def = 16'hACE1;
    m_sml = 16'h5670;
    repeat (4) @(negedge clk);
    checks++;
    if (bd.busy !== 1'b0 || bd.plot !== 1'b0 || bd.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%b plot=%b done=%b, want 0 0 0", bd.busy, bd.plot, bd.done);
    end
  endtask

  task automatic test_full_run();
    int b, p, ex, ey;
    gen_default_boxes();
    capture_default(1'b1, 1'b0, 1000, 6000);
    checks++;
    if (cap_to || !cap_done) begin
      errors++; $display("FAIL full_done: got done_seen=%0d, want 1", cap_done);
    end
    checks++;
    if (cap_n !== 256) begin
      errors++; $display("FAIL full_count: got %0d transfers, want 256", cap_n);
    end
    checks++;
    if (cap_x[0] !== 112 || cap_y[0] !== 86) begin
      errors++; $display("FAIL first_box: got (%0d,%0d), want (112,86)", cap_x[0], cap_y[0]);
    end
    for (int i = 0; i < cap_n && i < 256; i++) begin
      b = i / 16; p = i % 16;
      ex = ex0[b] + p % 4; ey = ey0[b] + p / 4;
      run0_x[i] = cap_x[i]; run0_y[i] = cap_y[i]; run0_c[i] = cap_c[i];
      checks++;
      if (cap_x[i] !== ex || cap_y[i] !== ey || cap_c[i] !== ec[b] || ex >= 160 || ey >= 120) begin
        errors++;
        $display("FAIL full_pixel %0d: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                 i, cap_x[i], cap_y[i], cap_c[i], ex, ey, ec[b]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bd.done !== 1'b1 || bd.plot !== 1'b0 || bd.busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done=%b plot=%b busy=%b, want 1 0 0", bd.done, bd.plot, bd.busy);
    end
  endtask

  task automatic test_start_held();
    int b, p, ex, ey;
    for (int run = 0; run < 2; run++) begin
      gen_default_boxes();
      capture_default(run == 0, 1'b1, 1000, 6000);
      checks++;
      if (cap_to || cap_n !== 256) begin
        errors++; $display("FAIL held_count run %0d: got %0d transfers, want 256", run, cap_n);
      end
      for (int i = 0; i < cap_n && i < 256; i++) begin
        b = i / 16; p = i % 16;
        ex = ex0[b] + p % 4; ey = ey0[b] + p / 4;
        checks++;
        if (cap_x[i] !== ex || cap_y[i] !== ey || cap_c[i] !== ec[b]) begin
          errors++;
          $display("FAIL held_pixel %0d.%0d: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                   run, i, cap_x[i], cap_y[i], cap_c[i], ex, ey, ec[b]);
        end
      end
      if (run == 0) begin
        @(negedge clk);
        checks++;
        if (bd.done !== 1'b0 || bd.busy !== 1'b1) begin
          errors++; $display("FAIL held_restart: got done=%b busy=%b, want 0 1", bd.done, bd.busy);
        end
      end
    end
    bd.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bd.done !== 1'b1 || bd.busy !== 1'b0) begin
      errors++; $display("FAIL held_release: got done=%b busy=%b, want 1 0", bd.done, bd.busy);
    end
  endtask

  task automatic test_reset_mid();
    capture_default(1'b1, 1'b0, 37, 3000);
    checks++;
    if (cap_to || bd.plot !== 1'b1) begin
      errors++; $display("FAIL mid_reach: got transfers=%0d plot=%b, want 37 1", cap_n, bd.plot);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bd.plot !== 1'b0 || bd.busy !== 1'b0 || bd.done !== 1'b0 || bd.x !== 8'd0 || bd.y !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: got plot=%b busy=%b done=%b x=%0d y=%0d, want 0 0 0 0 0",
               bd.plot, bd.busy, bd.done, bd.x, bd.y);
    end
    @(negedge clk);
    reset = 1'b0;
    m_def = 16'hACE1;
    m_sml = 16'h5670;
    capture_default(1'b1, 1'b0, 1000, 6000);
    checks++;
    if (cap_to || cap_n !== 256) begin
      errors++; $display("FAIL replay_count: got %0d transfers, want 256", cap_n);
    end
    for (int i = 0; i < cap_n && i < 256; i++) begin
      checks++;
      if (cap_x[i] !== run0_x[i] || cap_y[i] !== run0_y[i] || cap_c[i] !== run0_c[i]) begin
        errors++;
        $display("FAIL replay_pixel %0d: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                 i, cap_x[i], cap_y[i], cap_c[i], run0_x[i], run0_y[i], run0_c[i]);
      end
    end
  endtask

  task automatic test_stall();
    int x0, y0, cand, n, gen_cyc, ex, ey;
    logic [2:0] c0, hc;
    logic [2:0] hx, hy;
    bit first_seen, stalled, fin;
    model_box(m_sml, 3, 3, 4, 4, x0, y0, c0, cand);
    n = 0; gen_cyc = 0; first_seen = 0; stalled = 0; fin = 0;
    hx = 3'd0; hy = 3'd0; hc = 3'd0;
    @(negedge clk); bs.start = 1'b1; bs.pixel_ready = 1'b1;
    @(negedge clk); bs.start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      bs.pixel_ready = (c % 2 == 0);
      if (bs.done) begin fin = 1; break; end
      if (stalled) begin
        checks++;
        if (bs.x !== hx || bs.y !== hy || bs.colour !== hc || bs.plot !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: got (%0d,%0d,c%0d,plot%b), want (%0d,%0d,c%0d,plot1)",
                   bs.x, bs.y, bs.colour, bs.plot, hx, hy, hc);
        end
      end
      stalled = 0;
      if (bs.plot) begin
        first_seen = 1;
        if (bs.pixel_ready) begin
          ex = x0 + n % 4; ey = y0 + n / 4;
          checks++;
          if (int'(bs.x) !== ex || int'(bs.y) !== ey || bs.colour !== c0) begin
            errors++;
            $display("FAIL stall_pixel %0d: got (%0d,%0d,c%0d), want (%0d,%0d,c%0d)",
                     n, bs.x, bs.y, bs.colour, ex, ey, c0);
          end
          n++;
        end else begin
          stalled = 1; hx = bs.x; hy = bs.y; hc = bs.colour;
        end
      end else if (bs.busy && !first_seen) begin
        gen_cyc++;
      end
      @(negedge clk);
    end
    checks++;
    if (!fin || n !== 16) begin
      errors++; $display("FAIL stall_count: got %0d transfers done=%0d, want 16 1", n, fin);
    end
    checks++;
    if (gen_cyc !== 3 || x0 !== 4 || y0 !== 3) begin
      errors++; $display("FAIL small_first: got gen=%0d origin (%0d,%0d), want gen=3 origin (4,3)", gen_cyc, x0, y0);
    end
  endtask

  task automatic test_small_screen();
    int x0, y0, cand, n, gen_cyc, fx, fy;
    logic [2:0] c0;
    bit fin;
    for (int run = 0; run < 3; run++) begin
      model_box(m_sml, 3, 3, 4, 4, x0, y0, c0, cand);
      n = 0; gen_cyc = 0; fin = 0; fx = -1; fy = -1;
      @(negedge clk); bs.start = 1'b1; bs.pixel_ready = 1'b1;
      @(negedge clk); bs.start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        if (bs.done) begin fin = 1; break; end
        if (bs.plot) begin
          if (n == 0) begin fx = int'(bs.x); fy = int'(bs.y); end
          n++;
        end else if (bs.busy && n == 0) begin
          gen_cyc++;
        end
        @(negedge clk);
      end
      checks++;
      if (!fin || n !== 16 || gen_cyc !== cand || fx !== x0 || fy !== y0 || fx > 4 || fy > 4) begin
        errors++;
        $display("FAIL small_run %0d: got n=%0d gen=%0d origin (%0d,%0d), want n=16 gen=%0d origin (%0d,%0d) <=4",
                 run, n, gen_cyc, fx, fy, cand, x0, y0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_start_held();
    test_reset_mid();
    test_stall();
    test_small_screen();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want bench completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/random_box_painter.md
RANDOM_BOX_PAINTER -- requirements
Module: random_box_painter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, drawable width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, drawable height in pixels.
REQ-003 SHALL have parameter X_W, default 8, and Y_W, default 7, the coordinate widths.
REQ-004 SHALL have parameter BOX_W, default 4, and BOX_H, default 4, the box size in pixels, each 1..16.
REQ-005 SHALL have parameter NUM_BOXES, default 16, the boxes per run, 1..255.
REQ-006 SHALL have parameter SEED, default 16'hACE1, the LFSR reset value; 0 SHALL be replaced by 16'hACE1.
REQ-007 SHALL have parameter COLOUR, default 3'b111, the fixed box colour.
REQ-008 SHALL have port clk  in  1  sole clock, rising edge.
REQ-009 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-010 SHALL have port start  in  1  run request, sampled in IDLE and DONE.
REQ-011 SHALL have port pixel_ready  in  1  sink accepts the current pixel.
REQ-012 SHALL have port x  out  X_W  pixel x coordinate.
REQ-013 SHALL have port y  out  Y_W  pixel y coordinate.
REQ-014 SHALL have port colour  out  3  pixel colour.
REQ-015 SHALL have port plot  out  1  pixel valid.
REQ-016 SHALL have port busy  out  1  high in GEN, DRAW and NEXT.
REQ-017 SHALL have port done  out  1  run complete, held high in DONE.

Function
REQ-018 SHALL implement FSM states IDLE, GEN, DRAW, NEXT and DONE.
REQ-019 IDLE or DONE with start=1 SHALL clear box_count and enter GEN on the next edge; start SHALL be ignored in all other states.
REQ-020 SHALL hold a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifted once per cycle only in GEN.
REQ-021 The GEN candidate SHALL be cx = lfsr[X_W-1:0] and cy = lfsr[X_W+Y_W-1:X_W], taken from the pre-shift value.
REQ-022 GEN SHALL accept the candidate when cx <= SCREEN_W-BOX_W and cy <= SCREEN_H-BOX_H, latching x0/y0 and entering DRAW; otherwise it SHALL retry on the next cycle.
REQ-023 DRAW SHALL drive plot=1, x=x0+col and y=y0+row, with col and row starting at 0.
REQ-024 Advance SHALL occur only on plot&&pixel_ready; while pixel_ready=0, x, y and colour SHALL hold stable.
REQ-025 On advance, col SHALL increment, wrapping to 0 at BOX_W-1 and then incrementing row.
REQ-026 An advance on the pixel (BOX_W-1, BOX_H-1) SHALL enter NEXT.
REQ-027 NEXT SHALL last one cycle and increment box_count (8-bit); it SHALL enter DONE when the new count equals NUM_BOXES, otherwise GEN.
REQ-028 In DONE, done SHALL be 1 and plot 0 until start is asserted.
REQ-029 Outside DRAW, plot SHALL be 0 while x, y and colour hold their last values.
REQ-030 Each box SHALL emit exactly BOX_W*BOX_H plot transfers, with no pixel outside 0..SCREEN_W-1 / 0..SCREEN_H-1.

Reset
REQ-031 Asserting reset at any time SHALL immediately force IDLE, lfsr=SEED, box_count=0, col=row=0, x=y=0, colour=0, and plot=busy=done=0, abandoning any in-flight box.
REQ-032 After reset deasserts, the FSM SHALL remain in IDLE until start is asserted.

Configuration
REQ-033 With RANDOM_COLOUR_EN defined, colour SHALL be latched in GEN on acceptance as lfsr[15:13], with 3'b000 replaced by 3'b111.
REQ-034 Without RANDOM_COLOUR_EN, colour SHALL equal the COLOUR parameter for every box.

Verification
REQ-035 Defaults, reset then start pulse, pixel_ready=1 -> exactly 256 plot cycles, done rises, every box is a 4x4 contiguous raster and its coordinates match the LFSR reference model.
REQ-036 NUM_BOXES=1, pixel_ready toggling 1/0 each cycle -> 16 transfers total, and x/y/colour stable during every stall cycle.
REQ-037 SCREEN_W=SCREEN_H=8, BOX_W=BOX_H=4 -> GEN retries observed (busy high, plot 0), and all accepted x0,y0 <= 4.
REQ-038 Reset asserted mid-DRAW of box 3 -> plot/busy drop immediately, and a subsequent start reproduces the identical box sequence from SEED.
REQ-039 Start held high through a run -> no restart mid-run, and after DONE the next run begins with box_count=0.
REQ-040 RANDOM_COLOUR_EN defined -> colour never 3'b000 and constant within each box; undefined -> colour=3'b111 for all boxes.
